// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter driving a single-outstanding DV-pulse memory bus.
// Illegal requests are answered locally with an error; long memory stalls raise a sticky timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_address,
  input  logic [2:0]  i_p0_bhw,
  input  logic        i_p0_write,
  input  logic [31:0] i_p0_data,
  output logic        o_p0_ack,
  output logic        o_p0_rsp,
  output logic        o_p0_rsp_err,
  output logic [31:0] o_p0_data,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_address,
  input  logic [2:0]  i_p1_bhw,
  input  logic        i_p1_write,
  input  logic [31:0] i_p1_data,
  output logic        o_p1_ack,
  output logic        o_p1_rsp,
  output logic        o_p1_rsp_err,
  output logic [31:0] o_p1_data,
  output logic        o_bus_DV,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_data,
  output logic [2:0]  o_bhw,
  output logic        o_write_notread,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_DV,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          port_q, port_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [2:0]    bhw_q, bhw_d;
  logic          write_q, write_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        grant0, grant1, legal;
  logic [31:0] sel_addr, sel_data, rd_masked;
  logic [2:0]  sel_bhw;
  logic        sel_write;

  // Acks are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && i_rst_n) begin
      if (i_p0_req && (!i_p1_req || last_q)) begin
        grant0 = 1'b1;
      end else if (i_p1_req) begin
        grant1 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr  = grant1 ? i_p1_address : i_p0_address;
    sel_data  = grant1 ? i_p1_data    : i_p0_data;
    sel_bhw   = grant1 ? i_p1_bhw     : i_p0_bhw;
    sel_write = grant1 ? i_p1_write   : i_p0_write;
    unique case (sel_bhw)
      3'b100:  legal = (sel_addr[1:0] == 2'b00);
      3'b010:  legal = !sel_addr[0];
      3'b001:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    unique case (bhw_q)
      3'b001:  rd_masked = {24'h0, i_bus_data[7:0]};
      3'b010:  rd_masked = {16'h0, i_bus_data[15:0]};
      default: rd_masked = i_bus_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    port_d    = port_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bhw_d     = bhw_q;
    write_d   = write_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          port_d  = grant1;
          last_d  = grant1;
          addr_d  = sel_addr;
          wdata_d = sel_data;
          bhw_d   = sel_bhw;
          write_d = sel_write;
          rdata_d = '0;
          err_d   = !legal;
          state_d = legal ? ISSUE : RESP;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (i_bus_DV) begin
          if (!write_q) rdata_d = rd_masked;
          cnt_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      bhw_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      port_q    <= port_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bhw_q     <= bhw_d;
      write_q   <= write_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_p0_ack        = grant0;
  assign o_p1_ack        = grant1;
  assign o_p0_rsp        = (state_q == RESP) && !port_q;
  assign o_p1_rsp        = (state_q == RESP) &&  port_q;
  assign o_p0_rsp_err    = o_p0_rsp && err_q;
  assign o_p1_rsp_err    = o_p1_rsp && err_q;
  assign o_p0_data       = o_p0_rsp ? rdata_q : '0;
  assign o_p1_data       = o_p1_rsp ? rdata_q : '0;
  assign o_bus_DV        = (state_q == ISSUE);
  assign o_bus_address   = addr_q;
  assign o_bus_data      = wdata_q;
  assign o_bhw           = bhw_q;
  assign o_write_notread = write_q;
  assign o_busy          = (state_q != IDLE);
  assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a timestamp-based transaction model checked every cycle,
// plus literal expectations per scenario.
module tb_mem_bus_arbiter;
  localparam int unsigned TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        req[2]     = '{1'b0, 1'b0};
  logic [31:0] p_addr[2]  = '{32'h0, 32'h0};
  logic [2:0]  p_bhw[2]   = '{3'b000, 3'b000};
  logic        p_write[2] = '{1'b0, 1'b0};
  logic [31:0] p_wdata[2] = '{32'h0, 32'h0};
  logic        ack[2], rsp[2], rerr[2];
  logic [31:0] rdat[2];
  logic        bus_dv, bus_wr, busy, tmo;
  logic [31:0] bus_addr, bus_wdata;
  logic [2:0]  bus_bhw;
  logic        bus_dv_in = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int unsigned n_checks = 0, n_err = 0;
  bit chk_en = 1'b0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_p0_req(req[0]), .i_p0_address(p_addr[0]), .i_p0_bhw(p_bhw[0]),
    .i_p0_write(p_write[0]), .i_p0_data(p_wdata[0]),
    .o_p0_ack(ack[0]), .o_p0_rsp(rsp[0]), .o_p0_rsp_err(rerr[0]), .o_p0_data(rdat[0]),
    .i_p1_req(req[1]), .i_p1_address(p_addr[1]), .i_p1_bhw(p_bhw[1]),
    .i_p1_write(p_write[1]), .i_p1_data(p_wdata[1]),
    .o_p1_ack(ack[1]), .o_p1_rsp(rsp[1]), .o_p1_rsp_err(rerr[1]), .o_p1_data(rdat[1]),
    .o_bus_DV(bus_dv), .o_bus_address(bus_addr), .o_bus_data(bus_wdata),
    .o_bhw(bus_bhw), .o_write_notread(bus_wr),
    .i_bus_data(mem_rdata), .i_bus_DV(bus_dv_in),
    .o_busy(busy), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sized(input logic [31:0] d, input logic [2:0] b);
    if (b == 3'b001) return d & 32'h0000_00FF;
    if (b == 3'b010) return d & 32'h0000_FFFF;
    return d;
  endfunction

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] b);
    return (b == 3'b100 && a[1:0] == 2'b00) || (b == 3'b010 && !a[0]) || (b == 3'b001);
  endfunction

  // ---------------- transaction model (timestamps in cycle numbers) ----------------
  int unsigned cyc = 0;
  bit          m_busy, m_legal, m_rsp_known, m_tmo, m_last = 1'b1, m_port, m_write, m_err;
  int unsigned m_acc, m_rsp_cyc, m_wl, dv_in_cyc;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_bhw;

  function automatic int winner();
    if (req[0] && (!req[1] || m_last)) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_legal = 0; m_rsp_known = 0; m_tmo = 0; m_last = 1; m_port = 0;
      m_write = 0; m_err = 0; m_wl = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_bhw = 0;
    end else begin
      int w;
      if (bus_dv_in) dv_in_cyc = cyc;
      if (m_busy && m_legal && !m_rsp_known && cyc >= m_acc + 2) begin
        if (bus_dv_in) begin
          m_rsp_known = 1; m_rsp_cyc = cyc + 1; m_wl = 0;
          if (!m_write) m_rdata = sized(mem_rdata, m_bhw);
        end else begin
          m_wl++;
          if (m_wl >= TMO) m_tmo = 1;
        end
      end
      if (m_busy && m_rsp_known && cyc == m_rsp_cyc) begin
        m_busy = 0;
      end else if (!m_busy) begin
        w = winner();
        if (w >= 0) begin
          m_port = (w == 1); m_last = m_port;
          m_addr = p_addr[w]; m_bhw = p_bhw[w]; m_write = p_write[w]; m_wdata = p_wdata[w];
          m_legal = is_legal(m_addr, m_bhw); m_err = !m_legal; m_rdata = 0;
          m_acc = cyc; m_busy = 1;
          m_rsp_known = !m_legal; m_rsp_cyc = cyc + 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- memory responder ----------------
  int unsigned mem_lat = 0, mem_cnt = 0;
  bit kick_req = 0, kick_ack = 0;
  always @(negedge clk) begin
    bus_dv_in = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) bus_dv_in = 1'b1;
    end
    if (bus_dv && mem_lat > 0) mem_cnt = mem_lat;
    if (kick_req != kick_ack) begin
      bus_dv_in = 1'b1;
      kick_ack = kick_req;
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int unsigned dv_cnt = 0, rsp_cnt[2] = '{0, 0}, last_rsp_cyc[2], acc_cyc;
  logic [31:0] last_rdat[2], dv_addr, dv_wdata;
  logic        last_err[2], dv_wr;
  logic [2:0]  dv_bhw;
  int          ack_log[$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int p = 0; p < 2; p++) begin
        bit er;
        er = m_busy && m_rsp_known && cyc == m_rsp_cyc && (m_port == (p == 1));
        chk($sformatf("ack%0d", p), ack[p], rst_n && !m_busy && winner() == p);
        chk($sformatf("rsp%0d", p), rsp[p], er);
        chk($sformatf("rsp_err%0d", p), rerr[p], er && m_err);
        chk($sformatf("rdata%0d", p), rdat[p], er ? m_rdata : 32'h0);
        if (rsp[p]) begin
          rsp_cnt[p]++; last_rdat[p] = rdat[p]; last_err[p] = rerr[p]; last_rsp_cyc[p] = cyc;
        end
        if (ack[p] && req[p]) begin
          ack_log.push_back(p); acc_cyc = cyc;
        end
      end
      chk("bus_dv", bus_dv, m_busy && m_legal && cyc == m_acc + 1);
      chk("bus_addr", bus_addr, m_addr);
      chk("bus_data", bus_wdata, m_wdata);
      chk("bus_bhw", bus_bhw, m_bhw);
      chk("bus_write", bus_wr, m_write);
      chk("busy", busy, m_busy);
      chk("timeout", tmo, m_tmo);
      if (bus_dv) begin
        dv_cnt++; dv_addr = bus_addr; dv_wdata = bus_wdata; dv_bhw = bus_bhw; dv_wr = bus_wr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input int p, input logic [31:0] a, input logic [2:0] b,
                        input logic w, input logic [31:0] d, input bit hold);
    int unsigned n = 0;
    req[p] = 1'b1; p_addr[p] = a; p_bhw[p] = b; p_write[p] = w; p_wdata[p] = d;
    do begin
      @(negedge clk); n++;
    end while (!ack[p] && n < 200);
    if (!ack[p]) begin
      n_checks++; n_err++;
      $display("FAIL ack_wait: port %0d got no ack, required one within 200 cycles", p);
    end
    @(posedge clk); #1;
    if (!hold) req[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    do begin
      @(negedge clk); n++;
    end while (busy && n < 200);
    n_checks++;
    if (busy) begin
      n_err++;
      $display("FAIL idle_wait: busy still 1, required 0 within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  initial begin
    int unsigned d0, r0, r1, a0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_addr", bus_addr, 0);
    chk("reset_timeout", tmo, 0);
    @(posedge clk); #1;

    // word load
    d0 = dv_cnt; mem_lat = 8; mem_rdata = 32'hDEAD_BEEF;
    do_req(0, 32'h10, 3'b100, 1'b0, 32'h0, 0);
    wait_idle();
    chk("wl_dv_count", dv_cnt - d0, 1);
    chk("wl_dv_addr", dv_addr, 32'h10);
    chk("wl_dv_bhw", dv_bhw, 3'b100);
    chk("wl_dv_write", dv_wr, 0);
    chk("wl_rsp_data", last_rdat[0], 32'hDEAD_BEEF);
    chk("wl_rsp_err", last_err[0], 0);
    chk("wl_rsp_timing", last_rsp_cyc[0], dv_in_cyc + 1);

    // half store
    mem_lat = 3;
    do_req(1, 32'h22, 3'b010, 1'b1, 32'hFFFF_1234, 0);
    wait_idle();
    chk("hs_dv_data", dv_wdata, 32'hFFFF_1234);
    chk("hs_dv_write", dv_wr, 1);
    chk("hs_rsp_data", last_rdat[1], 0);
    chk("hs_rsp_err", last_err[1], 0);

    // byte load
    mem_rdata = 32'hAAAA_AA34;
    do_req(0, 32'h22, 3'b001, 1'b0, 32'h0, 0);
    wait_idle();
    chk("bl_rsp_data", last_rdat[0], 32'h0000_0034);

    // misaligned word, then illegal size
    d0 = dv_cnt;
    do_req(0, 32'h13, 3'b100, 1'b0, 32'h0, 0);
    wait_idle();
    chk("mis_err", last_err[0], 1);
    chk("mis_data", last_rdat[0], 0);
    chk("mis_timing", last_rsp_cyc[0], acc_cyc + 1);
    do_req(0, 32'h0, 3'b011, 1'b0, 32'h0, 0);
    wait_idle();
    chk("bhw_err", last_err[0], 1);
    chk("bhw_timing", last_rsp_cyc[0], acc_cyc + 1);
    chk("illegal_no_dv", dv_cnt - d0, 0);

    // arbitration from reset
    do_reset();
    a0 = ack_log.size(); r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
    mem_lat = 2; mem_rdata = 32'h1234_5678;
    fork
      begin
        do_req(0, 32'h100, 3'b100, 1'b0, 32'h0, 1);
        do_req(0, 32'h104, 3'b100, 1'b0, 32'h0, 0);
      end
      begin
        do_req(1, 32'h200, 3'b100, 1'b0, 32'h0, 1);
        do_req(1, 32'h204, 3'b100, 1'b0, 32'h0, 0);
      end
    join
    wait_idle();
    chk("arb_count", ack_log.size() - a0, 4);
    for (int i = 0; i < 4; i++)
      if (a0 + i < ack_log.size()) chk($sformatf("arb_order%0d", i), ack_log[a0 + i], i % 2);
    chk("arb_rsp0", rsp_cnt[0] - r0, 2);
    chk("arb_rsp1", rsp_cnt[1] - r1, 2);

    // timeout: memory silent, late completion
    do_reset();
    mem_lat = 0; mem_rdata = 32'hCAFE_F00D;
    do_req(0, 32'h40, 3'b100, 1'b0, 32'h0, 0);
    repeat (17) @(negedge clk);
    chk("tmo_before", tmo, 0);
    @(negedge clk);
    chk("tmo_after", tmo, 1);
    repeat (22) @(negedge clk);
    chk("tmo_still_waiting", busy, 1);
    @(posedge clk); #1; kick_req = ~kick_req;
    wait_idle();
    chk("tmo_late_data", last_rdat[0], 32'hCAFE_F00D);
    chk("tmo_late_err", last_err[0], 0);
    chk("tmo_sticky", tmo, 1);

    // reset mid-WAIT
    do_req(0, 32'h80, 3'b100, 1'b0, 32'h0, 0);
    repeat (3) @(negedge clk);
    #2; rst_n = 1'b0; #1;
    chk("rst_busy", busy, 0);
    chk("rst_timeout", tmo, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_bhw", bus_bhw, 0);
    chk("rst_rsp", {rsp[0], rsp[1], rerr[0], rerr[1], bus_dv, bus_wr}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
    @(posedge clk); #1; kick_req = ~kick_req;
    repeat (3) @(negedge clk);
    chk("stale_dv_busy", busy, 0);
    chk("stale_dv_rsp", rsp_cnt[0] - r0, 0);
    mem_lat = 4;
    @(posedge clk); #1;
    do_req(1, 32'h300, 3'b100, 1'b1, 32'h5555_AAAA, 0);
    wait_idle();
    chk("post_rst_rsp", rsp_cnt[1] - r1, 1);
    chk("post_rst_err", last_err[1], 0);
    chk("post_rst_dv_data", dv_wdata, 32'h5555_AAAA);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
